// File: rtl/mem_port_arbiter.sv
// N-port memory arbiter: valid/ready request merge with grant lock under back-pressure and
// in-order read response routing. Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module mem_port_arbiter #(
    parameter int NumPorts       = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NumPorts-1:0]                 req_valid,
    output logic [NumPorts-1:0]                 req_ready,
    input  logic [NumPorts-1:0]                 req_wr,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr,
    input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata,
    output logic [NumPorts-1:0]                 rsp_valid,
    output logic [DataWidth-1:0]                rsp_rdata,
    output logic                                mem_valid,
    input  logic                                mem_ready,
    output logic                                mem_wr,
    output logic [AddrWidth-1:0]                mem_addr,
    output logic [DataWidth-1:0]                mem_wdata,
    input  logic                                mem_rsp_valid,
    input  logic [DataWidth-1:0]                mem_rdata,
    output logic                                err_unexp_rsp
);
    // state     | meaning
    // ST_IDLE   | no grant held, winner chosen combinationally each cycle
    // ST_LOCKED | memory stalled the granted request; port and fields frozen
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int FW = $clog2(MaxOutstanding);
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic                 state;
    logic [PW-1:0]        lock_port;
    logic                 lock_wr;
    logic [AddrWidth-1:0] lock_addr;
    logic [DataWidth-1:0] lock_wdata;

    logic [PW-1:0]        fifo_mem [MaxOutstanding];
    logic [FW-1:0]        wr_ptr, rd_ptr;
    logic [FW:0]          count;
    logic                 fifo_full, fifo_empty;

    logic [NumPorts-1:0]  eligible;
    logic [PW-1:0]        pick;
    logic                 pick_found;
    logic [PW-1:0]        grant_port;
    logic                 accept, push, pop;

    assign fifo_full  = (count == (FW+1)'(MaxOutstanding));
    assign fifo_empty = (count == '0);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumPorts; i++)
            eligible[i] = req_valid[i] & (req_wr[i] | ~fifo_full);
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick       = PW'(i);
                pick_found = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;

    // Descending scan so the candidate closest to rr_ptr overwrites the others.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (eligible[idx]) begin
                pick       = PW'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant_port == PW'(NumPorts - 1)) ? '0 : grant_port + 1'b1;
    end
`endif

    assign grant_port = (state == ST_LOCKED) ? lock_port : pick;
    assign mem_valid  = ~rst_n & ((state == ST_LOCKED) | pick_found);
    assign mem_wr     = (state == ST_LOCKED) ? lock_wr    : req_wr[pick];
    assign mem_addr   = (state == ST_LOCKED) ? lock_addr  : req_addr[pick];
    assign mem_wdata  = (state == ST_LOCKED) ? lock_wdata : req_wdata[pick];

    assign accept = mem_valid & mem_ready;
    assign push   = accept & ~mem_wr;
    assign pop    = ~rst_n & mem_rsp_valid & ~fifo_empty;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_port] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (pop) rsp_valid[fifo_mem[rd_ptr]] = 1'b1;
    end

    assign rsp_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= ST_IDLE;
            lock_port     <= '0;
            lock_wr       <= 1'b0;
            lock_addr     <= '0;
            lock_wdata    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_valid & ~mem_ready) begin
                        state      <= ST_LOCKED;
                        lock_port  <= pick;
                        lock_wr    <= req_wr[pick];
                        lock_addr  <= req_addr[pick];
                        lock_wdata <= req_wdata[pick];
                    end
                end
                default: begin
                    if (mem_ready) state <= ST_IDLE;
                end
            endcase
            if (push) begin
                fifo_mem[wr_ptr] <= grant_port;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FW+1)'(push) - (FW+1)'(pop);
            if (mem_rsp_valid & fifo_empty) err_unexp_rsp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized traffic,
// compared against a queue-based reference model (honours MEM_ARB_FIXED_PRIO_EN).
module tb_mem_port_arbiter;
    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           v, w;
    logic [N-1:0][AW-1:0]   a;
    logic [N-1:0][DW-1:0]   d;
    logic                   mem_ready, mem_rsp_valid;
    logic [DW-1:0]          mem_rdata;

    logic [N-1:0]           req_ready, rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic                   mem_valid, mem_wr, err_unexp_rsp;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;

    mem_port_arbiter #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
        .clk(clk), .rst_n(rst),
        .req_valid(v), .req_ready(req_ready), .req_wr(w), .req_addr(a), .req_wdata(d),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .err_unexp_rsp(err_unexp_rsp)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    int          m_q[$];
    int          m_rr;
    bit          m_lock, m_lwr, m_err;
    int          m_lport;
    logic [31:0] m_laddr, m_lwd;
    logic [N-1:0] last_rdy;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int pick();
        int start;
        start = 0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        start = m_rr;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i] && (w[i] || m_q.size() < MAXO)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rr = 0; m_lock = 0; m_err = 0; m_lport = 0;
        m_lwr = 0; m_laddr = '0; m_lwd = '0;
    endtask

    // One clock cycle: compare all outputs against the model, then advance the model.
    task automatic step();
        int win;
        bit e_mv, e_wr;
        logic [31:0] e_addr, e_wd;
        logic [N-1:0] e_rdy, e_rsp;
        #1;
        win = -1; e_mv = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_rdy = '0; e_rsp = '0;
        if (!rst) begin
            if (m_lock) begin
                win = m_lport; e_wr = m_lwr; e_addr = m_laddr; e_wd = m_lwd;
            end else begin
                win = pick();
                if (win >= 0) begin e_wr = w[win]; e_addr = a[win]; e_wd = d[win]; end
            end
            e_mv = (win >= 0);
            if (e_mv && mem_ready) e_rdy[win] = 1'b1;
            if (mem_rsp_valid && m_q.size() > 0) e_rsp[m_q[0]] = 1'b1;
        end
        chk("mem_valid", 64'(mem_valid), 64'(e_mv));
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (e_rsp != '0) chk("rsp_rdata", 64'(rsp_rdata), 64'(mem_rdata));
        if (e_mv) begin
            chk("mem_wr", 64'(mem_wr), 64'(e_wr));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        end
        chk("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));
        last_rdy = e_rdy;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (mem_rsp_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (e_mv && mem_ready) begin
                if (!e_wr) m_q.push_back(win);
                m_rr = (win + 1) % N;
                m_lock = 0;
            end else if (e_mv) begin
                m_lock = 1; m_lport = win; m_lwr = e_wr; m_laddr = e_addr; m_lwd = e_wd;
            end
        end
        #1;
    endtask

    initial begin
        int g, pg;
        rst = 1; v = '0; w = '0; a = '0; d = '0;
        mem_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; last_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 0;
        #1 chk("reset_err", 64'(err_unexp_rsp), 64'(0));
        step();

        // Ports 0 and 1 reading back to back, responses one cycle later.
        v = 3'b011; w = '0; a[0] = 32'h1000; a[1] = 32'h2000; mem_ready = 1;
        pg = 0;
        for (int c = 0; c < 6; c++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = c % 2;
`endif
            mem_rsp_valid = (c > 0); mem_rdata = $urandom;
            #1 chk("alt_grant", 64'(req_ready), 64'(onehot(g)));
            if (c > 0) chk("alt_rsp", 64'(rsp_valid), 64'(onehot(pg)));
            step();
            pg = g;
        end
        v = '0; mem_rsp_valid = 1; mem_rdata = $urandom;
        step();
        mem_rsp_valid = 0;

        // Write stalled by memory; a later request from port 0 must wait.
        v = 3'b010; w = 3'b010; a[1] = 32'h100; d[1] = 32'hDEADBEEF; mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin v[0] = 1; w[0] = 0; a[0] = 32'h3000; end
            #1;
            chk("stall_addr", 64'(mem_addr), 64'h100);
            chk("stall_wdata", 64'(mem_wdata), 64'hDEADBEEF);
            chk("stall_ready", 64'(req_ready), 64'(0));
            step();
        end
        mem_ready = 1;
        #1 chk("stall_accept", 64'(req_ready), 64'(3'b010));
        step();
        v[1] = 0; w[1] = 0;
        #1 chk("after_stall", 64'(req_ready), 64'(3'b001));
        step();
        repeat (3) step();

        // FIFO full: reads blocked even with a same-cycle pop, writes pass.
        v = 3'b101; w = 3'b100; a[2] = 32'h4000; d[2] = $urandom;
        #1 chk("full_blk", 64'(req_ready), 64'(3'b100));
        step();
        v[2] = 0; w[2] = 0; mem_rsp_valid = 1; mem_rdata = $urandom;
        #1 chk("full_pop_blk", 64'(req_ready), 64'(0));
        chk("full_pop_rsp", 64'(rsp_valid), 64'(3'b001));
        step();
        mem_rsp_valid = 0;
        #1 chk("slot_free", 64'(req_ready), 64'(3'b001));
        step();
        v = '0; mem_rsp_valid = 1;
        repeat (4) begin mem_rdata = $urandom; step(); end

        // Unexpected response with nothing outstanding.
        mem_rdata = $urandom;
        #1 chk("unexp_rsp", 64'(rsp_valid), 64'(0));
        step();
        mem_rsp_valid = 0;
        #1 chk("unexp_err", 64'(err_unexp_rsp), 64'(1));
        step(); step();

        // Reset with two reads outstanding.
        v = 3'b001; w = '0;
        step(); step();
        rst = 1; v = 3'b011;
        #1 chk("rst_mv", 64'(mem_valid), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        step();
        rst = 0; v = '0;
        #1 chk("rst_err_clr", 64'(err_unexp_rsp), 64'(0));
        step();
        mem_rsp_valid = 1; mem_rdata = $urandom;
        #1 chk("post_rst_rsp", 64'(rsp_valid), 64'(0));
        step();
        mem_rsp_valid = 0;
        #1 chk("post_rst_err", 64'(err_unexp_rsp), 64'(1));
        step();
        rst = 1; step();
        rst = 0; v = 3'b011;
        #1 chk("rr_reset", 64'(req_ready), 64'(3'b001));
        step();

        // Randomized traffic respecting the hold-while-stalled rule.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !last_rdy[i])) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    w[i] = ($urandom_range(0, 3) == 0);
                    a[i] = $urandom;
                    d[i] = $urandom;
                end
            end
            mem_ready     = ($urandom_range(0, 99) < 70);
            mem_rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata     = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port memory arbiter that merges the core's per-stage memory requestors (instruction fetch, load/store, later a second fetch lane or debug port) onto one shared memory bus. Arbitrates with a valid/ready handshake, holds the granted request stable under back-pressure, and routes in-order read responses back to the issuing port via an outstanding-read ID FIFO. Sits between the core's memory ports and the memory/cache controller.

## Interface
- NumPorts, 2, number of requestor ports (2..8); index 0 is the instruction fetch port.
- AddrWidth, 32, address width.
- DataWidth, 32, data width (MemBusWidth).
- MaxOutstanding, 4, depth of the outstanding-read ID FIFO (power of two, ≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-high (asserted when 1).
- req_valid  in  [NumPorts]  port i presents a request.
- req_ready  out  [NumPorts]  port i request accepted this cycle when valid&ready.
- req_wr  in  [NumPorts]  1 = write, 0 = read.
- req_addr  in  [NumPorts][AddrWidth]  request address.
- req_wdata  in  [NumPorts][DataWidth]  write data.
- rsp_valid  out  [NumPorts]  read data valid for port i.
- rsp_rdata  out  [DataWidth]  read data, shared by all ports.
- mem_valid  out  1  request to memory.
- mem_ready  in  1  memory accepts request.
- mem_wr, mem_addr, mem_wdata  out  1/AddrWidth/DataWidth  selected request fields.
- mem_rsp_valid  in  1  memory returns read data (in order).
- mem_rdata  in  DataWidth  read data.
- err_unexp_rsp  out  1  sticky: response received with no read outstanding.

## Operation
- Grant state: IDLE (no lock) and LOCKED (grant held). IDLE→LOCKED when mem_valid & !mem_ready; LOCKED→IDLE on mem_ready. In LOCKED the granted port, mem_wr, mem_addr, mem_wdata are frozen; no re-arbitration.
- In IDLE, winner selected combinationally among eligible ports, round-robin: search starts at rr_ptr; on accept, rr_ptr ← winner+1 (mod NumPorts, wraps NumPorts-1→0).
- Eligible: req_valid[i] and (req_wr[i] or ID FIFO not full).
- mem_valid = eligible winner exists; req_ready[winner] = mem_ready; all other req_ready = 0.
- Accepted read pushes winner index into ID FIFO. Writes push nothing, produce no response.
- FIFO full blocks reads regardless of a same-cycle pop; writes still proceed.
- mem_rsp_valid with FIFO non-empty: rsp_valid[head] = 1, rsp_rdata = mem_rdata, pop. Ports must always accept responses.
- mem_rsp_valid with FIFO empty: no rsp_valid, err_unexp_rsp set until reset.
- Simultaneous accept and response: push and pop both occur; count unchanged.

## Timing
- Request path combinational: req → mem_* same cycle; mem_ready → req_ready same cycle.
- Response path combinational: mem_rsp_valid → rsp_valid same cycle; zero added latency.
- Reset values: rr_ptr=0, state IDLE, FIFO empty, err_unexp_rsp=0; mem_valid, req_ready, rsp_valid all 0 during reset cycle.
- Reset mid-transaction: outstanding IDs discarded; later responses flag err_unexp_rsp.
- Port must hold req fields stable while valid & !ready (standard handshake).

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins (fetch port 0 highest); rr_ptr not implemented.
- Undefined: round-robin as above.

## Test plan
- Ports 0,1 request reads continuously, mem_ready=1, rsp 1 cycle later -> grants alternate 0,1,0,1; rsp_valid routed to matching port with correct data.
- Port 1 write addr 0x100 data 0xDEADBEEF, mem_ready low 3 cycles, port 0 raises valid meanwhile -> mem_addr/mem_wdata stay 0x100/0xDEADBEEF, port 0 granted only after accept.
- MaxOutstanding=4, 4 reads accepted, no responses -> 5th read blocked (req_ready=0), concurrent write accepted; one response then frees a slot next cycle.
- mem_rsp_valid pulse with FIFO empty -> no rsp_valid, err_unexp_rsp=1 until rst_n.
- Reset asserted with 2 reads outstanding -> all outputs 0, rr_ptr=0; post-reset response sets err_unexp_rsp.
- MEM_ARB_FIXED_PRIO_EN build, ports 0 and 1 always valid -> port 0 wins every cycle.
